// File: rtl/powlib_streamarb_pkg.sv
// powlib_streamarb_pkg
//   Shared definitions for the stream arbiter and its round-robin picker:
//   arbiter state encoding and the ceiling-log2 helper used to size the
//   pointer and index fields.
package powlib_streamarb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Ceiling log2, never less than 1 so a 1-bit field always exists.
  function automatic int powlib_clogb2(input int value);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < value) begin
        r = r + 1;
      end else begin
        r = r;
      end
    end
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/powlib_rrpick.sv
// powlib_rrpick
//   Combinational rotating priority encoder. Scans req starting at ptr,
//   wrapping from N-1 to 0, and reports the first set bit.
//   Ports:
//     req     in  N   request vector
//     ptr     in  PW  index with highest priority (must be < N)
//     gntvld  out 1   some request is set
//     gntidx  out PW  index of the selected request
module powlib_rrpick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          gntvld,
  output logic [PW-1:0] gntidx
);

  logic [PW:0] cand_s;

  // Walk the candidates in rotated order; first valid one wins.
  always_comb begin
    gntvld = 1'b0;
    gntidx = {PW{1'b0}};
    cand_s = {(PW+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      // One extra bit so ptr+k cannot overflow before the modulo.
      cand_s = {1'b0, ptr} + (PW+1)'(k);
      if (cand_s >= (PW+1)'(N)) begin
        cand_s = cand_s - (PW+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!gntvld && req[cand_s[PW-1:0]]) begin
        gntvld = 1'b1;
        gntidx = cand_s[PW-1:0];
      end else begin
        gntvld = gntvld;
      end
    end
  end

endmodule

// File: rtl/powlib_streamarb.sv
// powlib_streamarb
//   N-input round-robin arbiter sharing one valid/ready sink. With EBURST=1
//   the grant is held from the first beat of a burst through its last beat.
//   A one-entry registered output stage carries data, last and source index.
//   Ports:
//     clk      in  1          clock
//     rst      in  1          asynchronous active-low reset
//     reqdata  in  N*W        requester data, requester i at [i*W +: W]
//     reqlast  in  N          last-beat flag per requester
//     reqvld   in  N          requester valid
//     reqrdy   out N          requester ready (one-hot or zero)
//     outdata  out W          registered output data
//     outlast  out 1          registered last flag
//     outidx   out clog2(N)   source index of the output beat
//     outvld   out 1          output valid
//     outrdy   in  1          output ready
module powlib_streamarb
  import powlib_streamarb_pkg::*;
#(
  parameter int    N      = 4,
  parameter int    W      = 16,
  parameter int    EBURST = 1,
  parameter int    EDBG   = 0,
  parameter string ID     = "STREAMARB",
  localparam int   PW     = powlib_clogb2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] reqdata,
  input  logic [N-1:0]   reqlast,
  input  logic [N-1:0]   reqvld,
  output logic [N-1:0]   reqrdy,
  output logic [W-1:0]   outdata,
  output logic           outlast,
  output logic [PW-1:0]  outidx,
  output logic           outvld,
  input  logic           outrdy
);

  if (EDBG != 0 && N < 2) begin : g_badn
    $fatal(1, "%s: N must be at least 2", ID);
  end

  arb_state_t    state_r, state_nx_s;
  logic [PW-1:0] ptr_r, ptr_nx_s;
  logic [PW-1:0] lockidx_r, lockidx_nx_s;
  logic          pickvld_s;
  logic [PW-1:0] pickidx_s;
  logic          gntvld_s;
  logic [PW-1:0] gnt_s;
  logic          srdy_s;
  logic          xfer_s;

  // Advance an index by one, wrapping at N (N need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] v);
    logic [PW:0] s;
    s = {1'b0, v} + {{PW{1'b0}}, 1'b1};
    if (s >= (PW+1)'(N)) begin
      s = {(PW+1){1'b0}};
    end else begin
      s = s;
    end
    return s[PW-1:0];
  endfunction

  powlib_rrpick #(.N(N), .PW(PW)) u_pick (
    .req    (reqvld),
    .ptr    (ptr_r),
    .gntvld (pickvld_s),
    .gntidx (pickidx_s)
  );

  assign srdy_s = !outvld || outrdy;

  // Grant source: rotating pick when idle, held index while locked.
  always_comb begin
    gnt_s    = pickidx_s;
    gntvld_s = pickvld_s;
    if (state_r == LOCK) begin
      gnt_s    = lockidx_r;
      gntvld_s = 1'b1;
    end else begin
      gnt_s    = pickidx_s;
      gntvld_s = pickvld_s;
    end
  end

  // One-hot ready toward the granted requester; silenced during reset.
  always_comb begin
    reqrdy = {N{1'b0}};
    if (rst && gntvld_s) begin
      reqrdy[gnt_s] = srdy_s;
    end else begin
      reqrdy = {N{1'b0}};
    end
  end

  assign xfer_s = gntvld_s && reqvld[gnt_s] && reqrdy[gnt_s];

  // Arbiter next state: pointer moves past the winner when a burst ends.
  always_comb begin
    state_nx_s   = state_r;
    ptr_nx_s     = ptr_r;
    lockidx_nx_s = lockidx_r;
    case (state_r)
      IDLE: begin
        if (xfer_s && (reqlast[gnt_s] || EBURST == 0)) begin
          ptr_nx_s = ptr_inc(gnt_s);
        end else if (xfer_s) begin
          lockidx_nx_s = gnt_s;
          state_nx_s   = LOCK;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOCK: begin
        if (xfer_s && reqlast[lockidx_r]) begin
          ptr_nx_s   = ptr_inc(lockidx_r);
          state_nx_s = IDLE;
        end else begin
          state_nx_s = LOCK;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      ptr_r     <= {PW{1'b0}};
      lockidx_r <= {PW{1'b0}};
    end else begin
      state_r   <= state_nx_s;
      ptr_r     <= ptr_nx_s;
      lockidx_r <= lockidx_nx_s;
    end
  end

  // Output stage: load on transfer, drain on outrdy, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outvld  <= 1'b0;
      outdata <= {W{1'b0}};
      outlast <= 1'b0;
      outidx  <= {PW{1'b0}};
    end else if (xfer_s) begin
      outvld  <= 1'b1;
      outdata <= reqdata[gnt_s*W +: W];
      outlast <= reqlast[gnt_s];
      outidx  <= gnt_s;
    end else if (outrdy) begin
      outvld  <= 1'b0;
    end else begin
      outvld  <= outvld;
    end
  end

endmodule

// File: doc/powlib_streamarb.md
Name: powlib_streamarb

Overview:
- N-input round-robin arbiter that shares one valid/ready stream sink among N requester streams, e.g. N powlib_sfifo read ports draining into one powlib_sfifo write port or one shared bus.
- Burst-aware: optionally holds the grant from the first beat through the `last` beat of a burst.
- Has a one-entry registered output stage and reports the source index with each beat.

Parameters:
- N, 4, number of requesters (N>=2).
- W, 16, data width per requester.
- EBURST, 1, 1 = hold the grant until a beat with reqlast=1 transfers; 0 = re-arbitrate after every beat.
- EDBG, 0, enable debug $display statements.
- ID, "STREAMARB", string identifier used in debug output.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- reqdata  in  N*W  requester data; requester i occupies bits [i*W +: W].
- reqlast  in  N  last-beat-of-burst flag per requester.
- reqvld  in  N  requester valid.
- reqrdy  out  N  requester ready; at most one bit is set.
- outdata  out  W  registered output data.
- outlast  out  1  registered last flag.
- outidx  out  clog2(N)  index of the requester that supplied the current output beat.
- outvld  out  1  output valid.
- outrdy  in  1  output ready.

Behaviour:
- Reset (rst=0, takes effect immediately, independent of clk):
  - outvld=0, outdata=0, outlast=0, outidx=0.
  - Round-robin pointer ptr=0; state=IDLE.
  - reqrdy forced to all-zero while rst=0.
- Stage ready: srdy = !outvld || outrdy (one-entry pipeline register, full throughput).
- Grant selection in IDLE (combinational): the first i with reqvld[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N). No requester valid -> no grant; reqrdy=0.
- Grant in LOCK: the held index lockidx, regardless of the other reqvld bits.
- reqrdy[g] = srdy for the granted g; all other bits are 0.
- Transfer: reqvld[g] && reqrdy[g]. On the next edge:
  - outdata <= reqdata[g], outlast <= reqlast[g], outidx <= g, outvld <= 1.
  - Latency from requester transfer to outvld: 1 cycle.
- Output register with no transfer: if outvld && outrdy, then outvld <= 0. Otherwise outdata, outlast and outidx stay stable while outvld=1 && outrdy=0.
- State machine:
  - IDLE, transfer with (reqlast[g]=1 or EBURST=0): ptr <= (g+1) mod N; stay in IDLE.
  - IDLE, transfer with EBURST=1 and reqlast[g]=0: lockidx <= g; go to LOCK.
  - LOCK, transfer with reqlast=1: ptr <= (lockidx+1) mod N; go to IDLE.
  - LOCK, transfer with reqlast=0, or no transfer: stay in LOCK.
  - In LOCK a requester bubble (reqvld[lockidx]=0) does not release the grant.
- Pointer wrap: from N-1 the pointer advances to 0. Pointer arithmetic is done in clog2(N)+1 bits, then reduced modulo N; N does not need to be a power of 2.
- Simultaneous events:
  - Output drain and new transfer in the same cycle: the new beat is loaded, outvld stays 1, and no bubble is inserted.
  - A requester dropping reqvld mid-burst is legal.
  - Requester-side reqdata/reqlast changes while reqvld=1 && reqrdy=0 are the requester's protocol violation; the arbiter samples only on transfer.
- Reset mid-burst: the lock is abandoned and any pending output beat is discarded (outvld=0). Arbitration after reset restarts from ptr=0.
- EDBG=1:
  - Print ID, outidx and outdata on each output transfer.
  - $finish if N<2.

Decomposition:
- powlib_std.vh supplies powlib_clogb2 for the outidx and ptr widths.
- Package constants: state encodings IDLE=1'b0 and LOCK=1'b1.
- Sub-module powlib_rrpick (combinational rotating priority encoder):
  - Inputs: req[N], ptr.
  - Outputs: gntvld and gntidx.
  - Reusable by other arbiters in the library.
- State, ptr and lockidx registers are local to powlib_streamarb. The output stage is a powlib_flipflop with EVLD and width W+1+clog2(N), gated on transfer.

Test Plan:
- Reset check: hold rst=0 with all reqvld=1 -> reqrdy=0000, outvld=0, outidx=0. Release rst -> first grant goes to requester 0.
- Single-beat round robin: N=4, EBURST=0, reqvld=1111, all reqlast=1, outrdy=1, reqdata[i]=16'hA0+i -> outdata sequence A0,A1,A2,A3,A0, outidx 0,1,2,3,0, one beat per cycle.
- Burst lock: EBURST=1, req1 sends 3 beats (last on the 3rd) while req2 stays valid -> outidx=1,1,1 then 2. reqrdy[2]=0 throughout req1's burst, including a 2-cycle bubble on req1 mid-burst.
- Backpressure: outrdy=0 for 5 cycles with outvld=1 -> outdata/outidx held, reqrdy=0000. Raise outrdy -> beat drains and the next beat loads in the same cycle with no bubble.
- Skip and wrap: ptr=3, reqvld=0101 -> grant 0, then grant 2, then grant 0. Grants to the idle requesters 1 and 3 never occur.
- Reset mid-burst: assert rst during beat 2 of a 4-beat burst from req3 -> outvld=0 immediately. After release with reqvld=1111 -> grant 0, not 3.
